// File: rtl/rtype_exec_pkg.sv
// Shared types for the R-type execution cluster: operation encoding and funct decode.
package rtype_exec_pkg;

    typedef enum logic [3:0] {
        ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND
    } operation_t;

    localparam logic [6:0] FUNCT7_BASE = 7'h00;
    localparam logic [6:0] FUNCT7_ALT  = 7'h20;

    typedef struct packed {
        operation_t op;
        logic       error;
    } decode_t;

    function automatic decode_t decode_rtype(input logic [6:0] funct7, input logic [2:0] funct3);
        decode_t d;
        d.op    = ADD;
        d.error = 1'b0;
        if (funct7 == FUNCT7_BASE) begin
            unique case (funct3)
                3'd0: d.op = ADD;
                3'd1: d.op = SLL;
                3'd2: d.op = SLT;
                3'd3: d.op = SLTU;
                3'd4: d.op = XOR;
                3'd5: d.op = SRL;
                3'd6: d.op = OR;
                3'd7: d.op = AND;
            endcase
        end else if (funct7 == FUNCT7_ALT && funct3 == 3'd0) begin
            d.op = SUB;
        end else if (funct7 == FUNCT7_ALT && funct3 == 3'd5) begin
            d.op = SRA;
        end else begin
            d.error = 1'b1;
        end
        return d;
    endfunction

endpackage

// File: rtl/rtype_exec_pipe_if.sv
// Issue, register-load and result handshake bundle of the R-type execution cluster.
interface rtype_exec_pipe_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned REG_COUNT  = 32
);
    localparam int unsigned ADDR_W = $clog2(REG_COUNT);

    logic                  in_valid;
    logic                  in_ready;
    logic [ADDR_W-1:0]     rs1;
    logic [ADDR_W-1:0]     rs2;
    logic [ADDR_W-1:0]     rd;
    logic [6:0]            funct7;
    logic [2:0]            funct3;
    logic                  ld_en;
    logic [ADDR_W-1:0]     ld_addr;
    logic [DATA_WIDTH-1:0] ld_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [ADDR_W-1:0]     out_rd;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_z;
    logic                  out_ovf;
    logic                  out_error;

    modport master (
        output in_valid, rs1, rs2, rd, funct7, funct3, ld_en, ld_addr, ld_data, out_ready,
        input  in_ready, out_valid, out_rd, out_data, out_z, out_ovf, out_error
    );

    modport slave (
        input  in_valid, rs1, rs2, rd, funct7, funct3, ld_en, ld_addr, ld_data, out_ready,
        output in_ready, out_valid, out_rd, out_data, out_z, out_ovf, out_error
    );

endinterface

// File: rtl/alu_core.sv
// Combinational R-type ALU; overflow is flagged only for signed add/sub.
module alu_core
    import rtype_exec_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  operation_t            op,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  z,
    output logic                  ovf
);
    localparam int unsigned SHW = $clog2(DATA_WIDTH);
    localparam int unsigned MSB = DATA_WIDTH - 1;

    logic [SHW-1:0]        shamt;
    logic [DATA_WIDTH-1:0] sum;
    logic [DATA_WIDTH-1:0] diff;

    assign shamt = b[SHW-1:0];
    assign sum   = a + b;
    assign diff  = a - b;

    always_comb begin
        result = '0;
        ovf    = 1'b0;
        unique case (op)
            ADD: begin
                result = sum;
                ovf    = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
            end
            SUB: begin
                result = diff;
                ovf    = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
            end
            SLL:  result = a << shamt;
            SLT:  result = {{(DATA_WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
            SLTU: result = {{(DATA_WIDTH-1){1'b0}}, a < b};
            XOR:  result = a ^ b;
            SRL:  result = a >> shamt;
            SRA:  result = $unsigned($signed(a) >>> shamt);
            OR:   result = a | b;
            AND:  result = a & b;
            default: result = '0;
        endcase
        z = (result == '0);
    end

endmodule

// File: rtl/rtype_exec_pipe.sv
// Two-stage R-type execute: regfile read/decode into ID, ALU into the output register with
// writeback, ID-stage result forwarding and output back-pressure.
module rtype_exec_pipe
    import rtype_exec_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned REG_COUNT  = 32
) (
    input logic              clk,
    input logic              rst,
    rtype_exec_pipe_if.slave bus
);
    localparam int unsigned ADDR_W = $clog2(REG_COUNT);

    logic [DATA_WIDTH-1:0] regs [REG_COUNT];

    logic                  id_valid_q;
    logic [DATA_WIDTH-1:0] id_a_q;
    logic [DATA_WIDTH-1:0] id_b_q;
    operation_t            id_op_q;
    logic [ADDR_W-1:0]     id_rd_q;
    logic                  id_error_q;

    logic                  out_valid_q;
    logic [ADDR_W-1:0]     out_rd_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  out_ovf_q;
    logic                  out_z_q;
    logic                  out_error_q;

    logic                  stall;
    logic                  advance;
    logic                  accept;
    logic                  fwd_ok;
    logic                  wb_en;
    decode_t               dec;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
    logic [DATA_WIDTH-1:0] alu_result;
    logic                  alu_z;
    logic                  alu_ovf;

    alu_core #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_alu (
        .a      (id_a_q),
        .b      (id_b_q),
        .op     (id_op_q),
        .result (alu_result),
        .z      (alu_z),
        .ovf    (alu_ovf)
    );

    assign stall   = out_valid_q && !bus.out_ready;
    assign advance = id_valid_q && !stall;
    assign accept  = bus.in_valid && bus.in_ready;
    assign fwd_ok  = id_valid_q && (id_rd_q != '0) && !id_error_q;
    assign wb_en   = advance && (id_rd_q != '0) && !id_error_q;
    assign dec     = decode_rtype(bus.funct7, bus.funct3);

    // The ID-stage result is not yet in the regfile, so a dependent issue takes it directly.
    always_comb begin
        op_a = regs[bus.rs1];
        op_b = regs[bus.rs2];
        if (fwd_ok && id_rd_q == bus.rs1) op_a = alu_result;
        if (fwd_ok && id_rd_q == bus.rs2) op_b = alu_result;
    end

    // Register 0 is reset to zero and never written, so plain reads return 0 for it.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < REG_COUNT; i++) regs[i] <= '0;
        end else begin
            if (wb_en) regs[id_rd_q] <= alu_result;
            if (bus.ld_en && bus.ld_addr != '0) regs[bus.ld_addr] <= bus.ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_valid_q  <= 1'b0;
            id_a_q      <= '0;
            id_b_q      <= '0;
            id_op_q     <= ADD;
            id_rd_q     <= '0;
            id_error_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_rd_q    <= '0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
            out_z_q     <= 1'b0;
            out_error_q <= 1'b0;
        end else begin
            if (accept) begin
                id_valid_q <= 1'b1;
                id_a_q     <= op_a;
                id_b_q     <= op_b;
                id_op_q    <= dec.op;
                id_rd_q    <= bus.rd;
                id_error_q <= dec.error;
            end else if (advance) begin
                id_valid_q <= 1'b0;
            end

            if (advance) begin
                out_valid_q <= 1'b1;
                out_rd_q    <= id_rd_q;
                out_data_q  <= id_error_q ? '0 : alu_result;
                out_ovf_q   <= !id_error_q && alu_ovf;
                out_z_q     <= id_error_q || alu_z;
                out_error_q <= id_error_q;
            end else if (bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = !stall && !bus.ld_en;
    assign bus.out_valid = out_valid_q;
    assign bus.out_rd    = out_rd_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ovf   = out_ovf_q;
    assign bus.out_error = out_error_q;
    assign bus.out_z     = out_valid_q && out_z_q;

endmodule
